// File: rtl/pencase_dispense_if.sv
// Dispenser handshake bundle between the dispense controller and the
// pen-case dispenser mechanism.
//   disp_req   : controller -> dispenser, level request
//   disp_color : controller -> dispenser, 01 RED / 10 BLUE, 00 when idle
//   disp_ack   : dispenser -> controller, level acknowledge
interface pencase_dispense_if;
  logic       disp_req;
  logic [1:0] disp_color;
  logic       disp_ack;

  modport master (output disp_req, output disp_color, input disp_ack);
  modport slave  (input disp_req, input disp_color, output disp_ack);
endinterface

// File: rtl/pencase_dispense_ctrl.sv
// Shares one pen-case dispenser between two coin-slot detectors (A, B).
// Each slot's RED/BLUE purchase pulse is buffered one-deep, slots are
// served round-robin, per-color stock is tracked, the dispenser is driven
// through a req/ack handshake with timeout, and refunds are pulsed on
// overflow, out-of-stock or dispenser fault.
// Ports:
//   clock, n_rst           : clock (rising edge), async active-low reset
//   color_a, color_b       : one-cycle purchase pulses (01 RED, 10 BLUE)
//   refill                 : reload both stocks, clears fault
//   disp                   : dispenser handshake (master side)
//   refund_a, refund_b     : one-cycle refund pulses per slot
//   busy                   : not idle or a purchase is pending
//   fault                  : sticky dispenser timeout flag
//   stock_red, stock_blue  : remaining stock per color
module pencase_dispense_ctrl #(
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8,
  parameter int TIMEOUT    = 50
) (
  input  logic               clock,
  input  logic               n_rst,
  input  logic [1:0]         color_a,
  input  logic [1:0]         color_b,
  input  logic               refill,
  pencase_dispense_if.master disp,
  output logic               refund_a,
  output logic               refund_b,
  output logic               busy,
  output logic               fault,
  output logic [STOCK_W-1:0] stock_red,
  output logic [STOCK_W-1:0] stock_blue
);

  localparam int                 CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [STOCK_W-1:0] FULL = STOCK_W'(STOCK_INIT);
  localparam logic [1:0]         RED  = 2'b01;
  localparam logic [1:0]         BLUE = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_DROP, S_FAULT} state_e;

  state_e             state_q, state_d;
  logic [1:0]         pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic               last_b_q, last_b_d;    // 1: last grant went to slot B
  logic               grant_b_q, grant_b_d;  // slot owning the current request
  logic               req_q, req_d;
  logic [1:0]         color_q, color_d;
  logic               ref_a_q, ref_a_d, ref_b_q, ref_b_d;
  logic               fault_q, fault_d;
  logic               busy_q, busy_d;
  logic [STOCK_W-1:0] red_q, red_d, blue_q, blue_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               clr_a, clr_b;
  logic               pick_b;
  logic [1:0]         pick_color;
  logic               in_stock;

  function automatic logic valid_color(input logic [1:0] c);
    return (c == RED) || (c == BLUE);
  endfunction

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      pend_a_q  <= 2'b00;
      pend_b_q  <= 2'b00;
      last_b_q  <= 1'b1;
      grant_b_q <= 1'b0;
      req_q     <= 1'b0;
      color_q   <= 2'b00;
      ref_a_q   <= 1'b0;
      ref_b_q   <= 1'b0;
      fault_q   <= 1'b0;
      busy_q    <= 1'b0;
      red_q     <= FULL;
      blue_q    <= FULL;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pend_a_q  <= pend_a_d;
      pend_b_q  <= pend_b_d;
      last_b_q  <= last_b_d;
      grant_b_q <= grant_b_d;
      req_q     <= req_d;
      color_q   <= color_d;
      ref_a_q   <= ref_a_d;
      ref_b_q   <= ref_b_d;
      fault_q   <= fault_d;
      busy_q    <= busy_d;
      red_q     <= red_d;
      blue_q    <= blue_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_b_d   = last_b_q;
    grant_b_d  = grant_b_q;
    req_d      = req_q;
    color_d    = color_q;
    fault_d    = fault_q;
    red_d      = red_q;
    blue_d     = blue_q;
    cnt_d      = cnt_q;
    ref_a_d    = 1'b0;
    ref_b_d    = 1'b0;
    clr_a      = 1'b0;
    clr_b      = 1'b0;
    pick_b     = 1'b0;
    pick_color = 2'b00;
    in_stock   = 1'b0;

    // Refill overrides any decrement made below.
    unique case (state_q)
      S_IDLE: begin
        if (pend_a_q != 2'b00 || pend_b_q != 2'b00) begin
          pick_b     = (pend_b_q != 2'b00) && ((pend_a_q == 2'b00) || !last_b_q);
          pick_color = pick_b ? pend_b_q : pend_a_q;
          in_stock   = (pick_color == RED) ? (red_q != '0) : (blue_q != '0);
          last_b_d   = pick_b;
          grant_b_d  = pick_b;
          if (!in_stock) begin
            clr_a   = !pick_b;
            clr_b   = pick_b;
            ref_a_d = !pick_b;
            ref_b_d = pick_b;
          end else begin
            color_d = pick_color;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (disp.disp_ack) begin
          if (color_q == RED) red_d  = red_q - STOCK_W'(1);
          else                blue_d = blue_q - STOCK_W'(1);
          clr_a   = !grant_b_q;
          clr_b   = grant_b_q;
          req_d   = 1'b0;
          state_d = S_WAIT_DROP;
        end else if (cnt_q == CNT_LAST) begin
          fault_d = 1'b1;
          req_d   = 1'b0;
          color_d = 2'b00;
          clr_a   = !grant_b_q;
          clr_b   = grant_b_q;
          ref_a_d = !grant_b_q;
          ref_b_d = grant_b_q;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_DROP: begin
        if (!disp.disp_ack) begin
          color_d = 2'b00;
          state_d = S_IDLE;
        end
      end
      S_FAULT: begin
        clr_a = 1'b1;
        clr_b = 1'b1;
        if (refill) begin
          fault_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (refill) begin
      red_d  = FULL;
      blue_d = FULL;
    end

    // Clear first, then a new pulse may land in the freed slot.
    pend_a_d = clr_a ? 2'b00 : pend_a_q;
    pend_b_d = clr_b ? 2'b00 : pend_b_q;
    if (valid_color(color_a)) begin
      if (state_q == S_FAULT || pend_a_d != 2'b00) ref_a_d = 1'b1;
      else                                         pend_a_d = color_a;
    end
    if (valid_color(color_b)) begin
      if (state_q == S_FAULT || pend_b_d != 2'b00) ref_b_d = 1'b1;
      else                                         pend_b_d = color_b;
    end

    busy_d = (state_d != S_IDLE) || (pend_a_d != 2'b00) || (pend_b_d != 2'b00);
  end

  assign disp.disp_req   = req_q;
  assign disp.disp_color = color_q;
  assign refund_a        = ref_a_q;
  assign refund_b        = ref_b_q;
  assign busy            = busy_q;
  assign fault           = fault_q;
  assign stock_red       = red_q;
  assign stock_blue      = blue_q;

endmodule

// File: tb/tb_pencase_dispense_ctrl.sv
module tb_pencase_dispense_ctrl;
  localparam int STOCK_W    = 4;
  localparam int STOCK_INIT = 8;
  localparam int TIMEOUT    = 50;

  logic               clock = 1'b0;
  logic               n_rst = 1'b1;
  logic [1:0]         color_a = 2'b00;
  logic [1:0]         color_b = 2'b00;
  logic               refill = 1'b0;
  logic               refund_a, refund_b, busy, fault;
  logic [STOCK_W-1:0] stock_red, stock_blue;

  int errors = 0;
  int checks = 0;

  pencase_dispense_if disp();

  always #5 clock = ~clock;

  pencase_dispense_ctrl #(
    .STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .n_rst(n_rst), .color_a(color_a), .color_b(color_b),
    .refill(refill), .disp(disp), .refund_a(refund_a), .refund_b(refund_b),
    .busy(busy), .fault(fault), .stock_red(stock_red), .stock_blue(stock_blue)
  );

  // Behavioural reference: what the controller is doing, as flags and counts.
  int m_stock[2];   // [0] RED, [1] BLUE
  int m_pend[2];    // per slot: 0 none, 1 RED, 2 BLUE
  int m_who;        // slot being served
  int m_wait;       // cycles the current request has been high
  int m_color;
  bit m_last_b, m_asking, m_dropping, m_broken;
  bit m_req, m_ref_a, m_ref_b, m_fault, m_busy;

  task automatic model_reset();
    m_stock = '{STOCK_INIT, STOCK_INIT};
    m_pend = '{0, 0};
    m_who = 0; m_wait = 0; m_color = 0;
    m_last_b = 1'b1; m_asking = 1'b0; m_dropping = 1'b0; m_broken = 1'b0;
    m_req = 1'b0; m_ref_a = 1'b0; m_ref_b = 1'b0; m_fault = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] ca, input logic [1:0] cb,
                            input logic rf, input logic ack);
    int col[2];
    bit rfd[2];
    bit clr[2];
    bit was_broken;
    int w;
    col[0] = int'(ca); col[1] = int'(cb);
    rfd = '{1'b0, 1'b0};
    clr = '{1'b0, 1'b0};
    was_broken = m_broken;
    if (m_broken) begin
      clr = '{1'b1, 1'b1};
      if (rf) begin m_broken = 1'b0; m_fault = 1'b0; end
    end else if (m_dropping) begin
      if (!ack) begin m_dropping = 1'b0; m_color = 0; end
    end else if (m_asking) begin
      if (ack) begin
        if (!rf) m_stock[m_color-1] = m_stock[m_color-1] - 1;
        clr[m_who] = 1'b1;
        m_req = 1'b0; m_asking = 1'b0; m_dropping = 1'b1;
      end else if (m_wait == TIMEOUT) begin
        m_fault = 1'b1; m_req = 1'b0; m_color = 0;
        clr[m_who] = 1'b1; rfd[m_who] = 1'b1;
        m_asking = 1'b0; m_broken = 1'b1;
      end else begin
        m_wait = m_wait + 1;
      end
    end else if (m_pend[0] != 0 || m_pend[1] != 0) begin
      if (m_pend[0] != 0 && m_pend[1] != 0) w = m_last_b ? 0 : 1;
      else w = (m_pend[0] != 0) ? 0 : 1;
      m_last_b = (w == 1);
      m_who = w;
      if (m_stock[m_pend[w]-1] == 0) begin
        clr[w] = 1'b1; rfd[w] = 1'b1;
      end else begin
        m_color = m_pend[w]; m_req = 1'b1; m_asking = 1'b1; m_wait = 1;
      end
    end
    if (rf) m_stock = '{STOCK_INIT, STOCK_INIT};
    for (int s = 0; s < 2; s++) begin
      if (clr[s]) m_pend[s] = 0;
      if (col[s] == 1 || col[s] == 2) begin
        if (was_broken || m_pend[s] != 0) rfd[s] = 1'b1;
        else m_pend[s] = col[s];
      end
    end
    m_ref_a = rfd[0];
    m_ref_b = rfd[1];
    m_busy = m_asking || m_dropping || m_broken || m_pend[0] != 0 || m_pend[1] != 0;
  endtask

  function automatic logic [14:0] pk(input logic r, input logic [1:0] c,
                                     input logic ra, input logic rb,
                                     input logic b, input logic f,
                                     input logic [3:0] red, input logic [3:0] blue);
    return {r, c, ra, rb, b, f, red, blue};
  endfunction

  function automatic logic [14:0] dut_out();
    return pk(disp.disp_req, disp.disp_color, refund_a, refund_b, busy, fault,
              stock_red, stock_blue);
  endfunction

  function automatic logic [14:0] model_out();
    return pk(m_req, 2'(m_color), m_ref_a, m_ref_b, m_busy, m_fault,
              4'(m_stock[0]), 4'(m_stock[1]));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the reference, compare on the falling edge.
  task automatic cycle(input logic [1:0] ca, input logic [1:0] cb,
                       input logic rf, input logic ack);
    color_a = ca; color_b = cb; refill = rf; disp.disp_ack = ack;
    @(posedge clock);
    model_step(ca, cb, rf, ack);
    @(negedge clock);
    chk("model", 32'(dut_out()), 32'(model_out()));
  endtask

  typedef struct {
    logic [1:0]  ca;
    logic [1:0]  cb;
    logic        rf;
    logic        ack;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[21];

  logic [1:0] rca, rcb;
  logic       rrf, rack, stall;

  initial begin
    disp.disp_ack = 1'b0;
    model_reset();
    stall = 1'b0;

    //            ca     cb     rf    ack        req  col    ra    rb    busy  f     red    blue
    tbl[0]  = '{2'b01, 2'b00, 1'b0, 1'b0, pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 4'd8)};
    tbl[1]  = '{2'b00, 2'b00, 1'b0, 1'b0, pk(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 4'd8)};
    tbl[2]  = '{2'b00, 2'b00, 1'b0, 1'b0, pk(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 4'd8)};
    tbl[3]  = '{2'b00, 2'b00, 1'b0, 1'b0, pk(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 4'd8)};
    tbl[4]  = '{2'b00, 2'b00, 1'b0, 1'b1, pk(1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 4'd8)};
    tbl[5]  = '{2'b00, 2'b00, 1'b0, 1'b0, pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 4'd8)};
    tbl[6]  = '{2'b00, 2'b00, 1'b0, 1'b0, pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 4'd8)};
    tbl[7]  = '{2'b10, 2'b01, 1'b0, 1'b0, pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 4'd8)};
    tbl[8]  = '{2'b00, 2'b00, 1'b0, 1'b0, pk(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 4'd8)};
    tbl[9]  = '{2'b00, 2'b00, 1'b0, 1'b1, pk(1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 4'd8)};
    tbl[10] = '{2'b00, 2'b00, 1'b0, 1'b0, pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 4'd8)};
    tbl[11] = '{2'b00, 2'b00, 1'b0, 1'b0, pk(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 4'd8)};
    tbl[12] = '{2'b00, 2'b00, 1'b0, 1'b1, pk(1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 4'd7)};
    tbl[13] = '{2'b00, 2'b00, 1'b0, 1'b0, pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 4'd7)};
    tbl[14] = '{2'b01, 2'b00, 1'b0, 1'b0, pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 4'd7)};
    tbl[15] = '{2'b01, 2'b00, 1'b0, 1'b0, pk(1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 4'd7)};
    tbl[16] = '{2'b00, 2'b00, 1'b0, 1'b0, pk(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 4'd7)};
    tbl[17] = '{2'b00, 2'b00, 1'b0, 1'b1, pk(1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 4'd7)};
    tbl[18] = '{2'b00, 2'b00, 1'b0, 1'b0, pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 4'd7)};
    tbl[19] = '{2'b00, 2'b00, 1'b1, 1'b0, pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 4'd8)};
    tbl[20] = '{2'b11, 2'b00, 1'b0, 1'b0, pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 4'd8)};

    // Reset state
    #1 n_rst = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("reset_state", 32'(dut_out()), 32'(pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 4'd8)));
    n_rst = 1'b1;

    // Directed vectors from reset
    for (int i = 0; i < 21; i++) begin
      cycle(tbl[i].ca, tbl[i].cb, tbl[i].rf, tbl[i].ack);
      chk($sformatf("vec%0d", i), 32'(dut_out()), 32'(tbl[i].exp));
    end

    // Drain BLUE, then an out-of-stock purchase on slot B
    for (int i = 0; i < 8; i++) begin
      cycle(2'b10, 2'b00, 1'b0, 1'b0);
      cycle(2'b00, 2'b00, 1'b0, 1'b0);
      cycle(2'b00, 2'b00, 1'b0, 1'b1);
      cycle(2'b00, 2'b00, 1'b0, 1'b0);
    end
    chk("blue_drained", 32'(stock_blue), 32'd0);
    cycle(2'b00, 2'b10, 1'b0, 1'b0);
    cycle(2'b00, 2'b00, 1'b0, 1'b0);
    chk("oos_refund_b", 32'(refund_b), 32'd1);
    chk("oos_no_req", 32'(disp.disp_req), 32'd0);
    cycle(2'b00, 2'b00, 1'b0, 1'b0);
    chk("oos_refund_pulse_end", 32'(refund_b), 32'd0);
    chk("oos_blue_zero", 32'(stock_blue), 32'd0);

    // Dispenser timeout
    cycle(2'b00, 2'b00, 1'b1, 1'b0);
    cycle(2'b01, 2'b00, 1'b0, 1'b0);
    cycle(2'b00, 2'b00, 1'b0, 1'b0);
    chk("to_req_high", 32'(disp.disp_req), 32'd1);
    for (int i = 0; i < TIMEOUT - 1; i++) cycle(2'b00, 2'b00, 1'b0, 1'b0);
    chk("to_not_yet", 32'({disp.disp_req, fault}), 32'b10);
    cycle(2'b00, 2'b00, 1'b0, 1'b0);
    chk("to_fault", 32'({fault, refund_a, disp.disp_req, disp.disp_color}), 32'b11000);
    cycle(2'b00, 2'b01, 1'b0, 1'b0);
    chk("to_refund_end", 32'(refund_a), 32'd0);
    chk("fault_refund_b", 32'(refund_b), 32'd1);
    cycle(2'b00, 2'b00, 1'b1, 1'b0);
    chk("refill_clears", 32'({fault, busy, stock_red, stock_blue}), 32'({2'b00, 4'd8, 4'd8}));

    // Reset mid-request, then the first tie goes to slot A
    cycle(2'b00, 2'b00, 1'b0, 1'b0);
    cycle(2'b10, 2'b00, 1'b0, 1'b0);
    cycle(2'b00, 2'b00, 1'b0, 1'b0);
    chk("pre_rst_req", 32'(disp.disp_req), 32'd1);
    #2 n_rst = 1'b0;
    #1 chk("async_rst", 32'(dut_out()), 32'(pk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 4'd8)));
    model_reset();
    @(negedge clock);
    n_rst = 1'b1;
    cycle(2'b00, 2'b00, 1'b0, 1'b0);
    chk("rst_no_refund", 32'({refund_a, refund_b, busy}), 32'd0);
    cycle(2'b10, 2'b01, 1'b0, 1'b0);
    cycle(2'b00, 2'b00, 1'b0, 1'b0);
    chk("tie_a_first", 32'(disp.disp_color), 32'(2'b10));
    cycle(2'b00, 2'b00, 1'b0, 1'b1);
    cycle(2'b00, 2'b00, 1'b0, 1'b0);
    cycle(2'b00, 2'b00, 1'b0, 1'b0);
    chk("tie_b_next", 32'(disp.disp_color), 32'(2'b01));
    cycle(2'b00, 2'b00, 1'b0, 1'b1);
    cycle(2'b00, 2'b00, 1'b0, 1'b0);

    // Random traffic against the reference
    for (int i = 0; i < 4000; i++) begin
      rca = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      rcb = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      rrf = m_broken ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 299) == 0);
      if (m_asking) begin
        rack = !stall && ($urandom_range(0, 5) == 0);
      end else begin
        stall = ($urandom_range(0, 9) == 0);
        rack = m_dropping && ($urandom_range(0, 1) == 0);
      end
      cycle(rca, rcb, rrf, rack);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
